// File: rtl/barrel_seq_shifter.sv
// N-bit shift/rotate register with single-step modes and a counted multi-step
// operation (Start/Busy/Done) that performs one bit-step per clock.
module barrel_seq_shifter #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [2:0]    mode_i,
    input  logic          start_i,
    input  logic [AW-1:0] amount_i,
    input  logic          cin_i,
    input  logic [N-1:0]  data_i,
    output logic [N-1:0]  data_o,
    output logic          cout_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [2:0] M_KEEP  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic          cout_q, cout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;

    logic [2:0]    step_mode;
    logic [N-1:0]  step_data;
    logic          step_cout;
    logic          is_shift;

    // In RUN the latched mode drives the step; in IDLE the live mode does.
    assign step_mode = (state_q == RUN) ? mode_q : mode_i;
    assign is_shift  = (mode_i != M_KEEP) && (mode_i != M_LOAD) && (mode_i != M_CLEAR);

    always_comb begin
        step_data = data_q;
        step_cout = 1'b0;
        case (step_mode)
            M_LOAD:  step_data = data_i;
            M_SHL: begin
                step_data = {data_q[N-2:0], cin_i};
                step_cout = data_q[N-1];
            end
            M_SHR: begin
                step_data = {cin_i, data_q[N-1:1]};
                step_cout = data_q[0];
            end
            M_ROL: begin
                step_data = {data_q[N-2:0], data_q[N-1]};
                step_cout = data_q[N-1];
            end
            M_ROR: begin
                step_data = {data_q[0], data_q[N-1:1]};
                step_cout = data_q[0];
            end
            M_ASR: begin
                step_data = {data_q[N-1], data_q[N-1:1]};
                step_cout = data_q[0];
            end
            M_CLEAR: step_data = '0;
            default: step_data = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = step_data;
        cout_d  = step_cout;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start_i && is_shift) begin
                    if (amount_i == '0) begin
                        data_d = data_q;
                        cout_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        mode_d = mode_i;
                        if (amount_i == AW'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            cnt_d   = amount_i - AW'(1);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= M_KEEP;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign data_o = data_q;
    assign cout_o = cout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_barrel_seq_shifter.sv
// Scoreboard bench for barrel_seq_shifter (N=8, AW=4): expected results are
// queued when an operation is issued and popped when the DUT signals its result.
module tb_barrel_seq_shifter;

    localparam logic [2:0] M_KEEP  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mode;
    logic       start;
    logic [3:0] amount;
    logic       cin;
    logic [7:0] din;
    logic [7:0] dout;
    logic       cout, busy, done;

    typedef struct packed {
        logic [7:0] data;
        logic       cout;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_cout = 1'b0;

    barrel_seq_shifter #(.N(8), .AW(4)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .mode_i   (mode),
        .start_i  (start),
        .amount_i (amount),
        .cin_i    (cin),
        .data_i   (din),
        .data_o   (dout),
        .cout_o   (cout),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {cout, data} after one step of the reference behaviour.
    function automatic logic [8:0] model_step(logic [2:0] md, logic [7:0] v, logic c, logic [7:0] d);
        case (md)
            M_LOAD:  return {1'b0, d};
            M_SHL:   return {v[7], v[6:0], c};
            M_SHR:   return {v[0], c, v[7:1]};
            M_ROL:   return {v[7], v[6:0], v[7]};
            M_ROR:   return {v[0], v[0], v[7:1]};
            M_ASR:   return {v[0], v[7], v[7:1]};
            M_CLEAR: return 9'h000;
            default: return {1'b0, v};
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mode = M_KEEP; start = 1'b0; amount = 4'd0; cin = 1'b0; din = 8'h00;
        #12;
        vectors++;
        if ({dout, cout, busy, done} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset: got data=%h cout=%b busy=%b done=%b, want all zero", dout, cout, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_data = 8'h00; m_cout = 1'b0;
    endtask

    // Single edge in IDLE with start asserted or not; Done must stay low.
    task automatic test_single(string name, logic [2:0] md, logic st, logic c, logic [7:0] d);
        logic [8:0] r;
        exp_t got;
        r = model_step(md, m_data, c, d);
        exp_q.push_back('{data: r[7:0], cout: r[8]});
        mode = md; start = st; cin = c; din = d; amount = 4'd3;
        tick();
        got = exp_q.pop_front();
        vectors++;
        if ({dout, cout, busy, done} !== {got.data, got.cout, 2'b00}) begin
            miscompares++;
            $display("FAIL %s: got data=%h cout=%b busy=%b done=%b, want data=%h cout=%b busy=0 done=0",
                     name, dout, cout, busy, done, got.data, got.cout);
        end
        $display("txn %s mode=%0d start=%b -> data=%h cout=%b", name, md, st, dout, cout);
        m_data = got.data; m_cout = got.cout;
        mode = M_KEEP; start = 1'b0;
    endtask

    // Counted operation. noise drives Load/Start during RUN; tail=0 leaves the
    // Done cycle open so the caller can issue the next Start back-to-back.
    task automatic test_op(string name, logic [2:0] md, logic [3:0] amt, logic c, bit noise, bit tail);
        logic [8:0] r;
        exp_t e;
        int last;
        r = {1'b0, m_data};
        for (int i = 0; i < amt; i++) r = model_step(md, r[7:0], c, 8'h00);
        exp_q.push_back('{data: r[7:0], cout: (amt == 0) ? 1'b0 : r[8]});
        last = (amt == 0) ? 1 : int'(amt);
        mode = md; start = 1'b1; amount = amt; cin = c; din = 8'h5A;
        tick();
        mode = M_KEEP; start = 1'b0;
        if (noise) begin
            mode = M_LOAD; start = 1'b1; din = 8'h33; amount = 4'd1;
        end
        for (int j = 1; j <= last; j++) begin
            if (j > 1) tick();
            vectors++;
            if (busy !== (j < int'(amt)) || done !== (j == last)) begin
                miscompares++;
                $display("FAIL %s handshake edge %0d: got busy=%b done=%b, want busy=%b done=%b",
                         name, j, busy, done, (j < int'(amt)), (j == last));
            end
        end
        mode = M_KEEP; start = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (dout !== e.data || cout !== e.cout) begin
            miscompares++;
            $display("FAIL %s result: got data=%h cout=%b, want data=%h cout=%b", name, dout, cout, e.data, e.cout);
        end
        $display("txn %s mode=%0d amount=%0d cin=%b -> data=%h cout=%b", name, md, amt, c, dout, cout);
        m_data = e.data; m_cout = e.cout;
        if (tail) begin
            tick();
            vectors++;
            if ({dout, cout, busy, done} !== {m_data, 3'b000}) begin
                miscompares++;
                $display("FAIL %s after done: got data=%h cout=%b busy=%b done=%b, want data=%h cout=0 busy=0 done=0",
                         name, dout, cout, busy, done, m_data);
            end
            m_cout = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        test_single("load_ff", M_LOAD, 1'b0, 1'b0, 8'hFF);
        mode = M_SHL; start = 1'b1; amount = 4'd6; cin = 1'b0;
        tick();
        mode = M_KEEP; start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({dout, cout, busy, done} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got data=%h cout=%b busy=%b done=%b, want all zero", dout, cout, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_data = 8'h00; m_cout = 1'b0;
        tick();
        vectors++;
        if ({dout, cout, busy, done} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got data=%h cout=%b busy=%b done=%b, want all zero", dout, cout, busy, done);
        end
        test_single("load_c3", M_LOAD, 1'b0, 1'b0, 8'hC3);
        test_op("rol2_after_reset", M_ROL, 4'd2, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0] md;
        for (int i = 0; i < 12; i++) begin
            md = 3'($urandom_range(2, 6));
            test_single("rand_load", M_LOAD, 1'b0, 1'b0, 8'($urandom));
            test_op("rand_op", md, 4'($urandom_range(0, 15)), 1'($urandom), 1'b0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single("load_a5", M_LOAD, 1'b0, 1'b0, 8'hA5);
        test_op("shl3", M_SHL, 4'd3, 1'b0, 1'b0, 1'b1);
        test_single("load_81", M_LOAD, 1'b0, 1'b0, 8'h81);
        test_single("ror_step", M_ROR, 1'b0, 1'b0, 8'h00);
        test_single("rol_step", M_ROL, 1'b0, 1'b0, 8'h00);
        test_single("shr_step_cin1", M_SHR, 1'b0, 1'b1, 8'h00);
        test_single("start_load", M_LOAD, 1'b1, 1'b0, 8'h3C);
        test_single("start_clear", M_CLEAR, 1'b1, 1'b0, 8'h00);
        test_single("load_80", M_LOAD, 1'b0, 1'b0, 8'h80);
        test_op("asr4", M_ASR, 4'd4, 1'b0, 1'b0, 1'b1);
        test_op("shr0", M_SHR, 4'd0, 1'b0, 1'b0, 1'b1);
        test_op("shl1", M_SHL, 4'd1, 1'b1, 1'b0, 1'b1);
        test_single("load_ff", M_LOAD, 1'b0, 1'b0, 8'hFF);
        test_op("shl9", M_SHL, 4'd9, 1'b0, 1'b0, 1'b1);
        test_op("shr15_cin1", M_SHR, 4'd15, 1'b1, 1'b0, 1'b1);
        test_single("load_01", M_LOAD, 1'b0, 1'b0, 8'h01);
        test_op("rol5_noise", M_ROL, 4'd5, 1'b0, 1'b1, 1'b0);
        test_op("ror2_b2b", M_ROR, 4'd2, 1'b0, 1'b0, 1'b0);
        test_op("asr3_b2b", M_ASR, 4'd3, 1'b0, 1'b0, 1'b1);
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/barrel_seq_shifter.md
# barrel_seq_shifter

Parametrised N-bit shift/rotate register that adds rotate, arithmetic-shift and clear modes, plus a counted multi-step shift with Start/Busy/Done handshake. Single-step operation (keep, load, shift) is unchanged from the datapath register family. A multi-step shift performs one bit-step per clock for Amount steps, so a controller can shift or rotate by a variable amount without sequencing each step itself. It sits in the datapath between the register file and the ALU result bus.

## Interface
- N, 8, data width (N ≥ 2)
- AW, 4, width of Amount; shifts up to 2^AW−1 steps
- Clock  in  1  rising-edge clock
- ResetN  in  1  reset, asynchronous, active-low
- Mode  in  3  operation select: 000 Keep, 001 Load, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 Clear
- Start  in  1  request a counted multi-step operation, sampled only when idle
- Amount  in  AW  step count for Start
- CIn  in  1  serial fill bit for SHL/SHR, sampled on every step
- Input  in  N  parallel load data
- Output  out  N  register contents
- COut  out  1  bit shifted/rotated out on the most recent step
- Busy  out  1  multi-step operation in progress
- Done  out  1  one-cycle pulse after the final step of a Start operation

## Operation
- Reset (ResetN=0, any time): Output=0, COut=0, Busy=0, Done=0, step counter=0, latched mode=Keep, state IDLE. A pending multi-step operation is discarded.
- States: IDLE, RUN.
- Step semantics, one per edge:
  - SHL: Output={Output[N-2:0],CIn}, COut=Output[N-1]
  - SHR: Output={CIn,Output[N-1:1]}, COut=Output[0]
  - ROL: Output={Output[N-2:0],Output[N-1]}, COut=Output[N-1]
  - ROR: Output={Output[0],Output[N-1:1]}, COut=Output[0]
  - ASR: Output={Output[N-1],Output[N-1:1]}, COut=Output[0]
  - Keep: Output held, COut=0
  - Load: Output=Input, COut=0
  - Clear: Output=0, COut=0
- IDLE, Start=0: apply Mode as a single step each edge. Done=0.
- IDLE, Start=1, Mode ∈ {Keep, Load, Clear}: treated as Start=0. Done is not asserted.
- IDLE, Start=1, shift/rotate Mode, Amount=0: Output unchanged, COut=0, Done=1 next cycle, remain IDLE.
- IDLE, Start=1, shift/rotate Mode, Amount=k≥1:
  - Latch Mode and perform step 1 on the same edge.
  - k=1: Done=1, stay IDLE.
  - k≥2: counter=k−1, Busy=1, go to RUN.
- RUN: perform the latched step each edge and decrement the counter.
  - When the counter reaches 0: Busy=0, Done=1, return to IDLE.
  - Mode, Start, Amount and Input are ignored in RUN. CIn is still sampled per step.
- Amount ≥ N is legal and performs exactly Amount steps; e.g. SHL by N with CIn=0 yields 0.
- Done is high for exactly one cycle. Start asserted during the Done cycle is accepted (back-to-back operation).

## Timing
- All state changes occur on the rising Clock edge; ResetN acts immediately and asynchronously.
- Latency of a Start operation with Amount=k≥1 is k edges. Output holds the final value and Done=1 after edge k.
- Busy is high from after edge 1 through edge k−1 inclusive (k≥2). It is never high for k≤1.
- COut is registered alongside Output and is valid in the same cycle as the Output it accompanies.
- All outputs are registers; there is no combinational path from inputs to outputs.

## Test plan
- N=8: Load 0xA5, then Start SHL Amount=3 with CIn=0 → Busy high for 2 cycles, after 3 edges Output=0x28, COut=1, Done pulses 1 cycle.
- Load 0x81, single-step ROR (Start=0) → Output=0xC0, COut=1. Next single-step ROL → Output=0x81, COut=1.
- Load 0x80, Start ASR Amount=4 → Output=0xF8, COut=0, Done after 4 edges.
- Start SHR Amount=0 → Output unchanged, COut=0, Busy never high, Done=1 next cycle. Start SHL Amount=9 on 0xFF with CIn=0 → Output=0x00 after 9 edges.
- While RUN (Start ROL Amount=5 on 0x01), drive Start=1, Mode=Load, Input=0x33 → ignored, final Output=0x20. Start issued during the Done cycle → new operation begins on that edge.
- Assert ResetN=0 mid-way through a 6-step SHL → Output=0, COut=0, Busy=0, Done=0 immediately. After release, the next Start behaves normally.
